// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   state_e     - arbiter FSM states (IDLE / ISSUE / DONE)
//   F3_*        - RISC-V load/store size encodings carried on Funct3
//   STAT_W      - width of the optional statistics counters
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one position after
// last_grant and wraps modulo NREQ; the first requesting index wins.
// Ports:
//   req        in   NREQ   request vector
//   last_grant in   IDXW   index granted most recently
//   grant      out  NREQ   one-hot grant (all zero when nobody requests)
//   grant_idx  out  IDXW   binary index of the winner
//   any        out  1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    int              sum;
    logic [IDXW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            // Wrap without a modulo so non-power-of-two NREQ works.
            sum = int'(last_grant) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = sum[IDXW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between NREQ requesters. Each access is
// serialised through IDLE -> ISSUE -> DONE: accept in IDLE (req_ready pulse),
// drive the memory strobes for exactly one cycle in ISSUE, pulse rsp_valid to
// the owner in DONE. Round-robin arbitration, requester 0 wins first.
//
// Optional build macro: DMEM_ARB_STATS_EN adds saturating grant counters per
// requester (stat_grants) and a contention counter (stat_conflicts).
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/we             per-requester request and direction (1 = store)
//   req_addr/wdata/funct3    packed per-requester payload, slice i = req i
//   req_ready                one-hot acceptance pulse
//   rsp_valid                one-hot completion pulse (loads and stores)
//   rsp_rdata                load data, valid with rsp_valid
//   mem_read/write/addr/wdata/funct3   to data memory
//   mem_rdata                from data memory
//   stat_grants, stat_conflicts        (DMEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*DM_ADDRESS-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*3-1:0]          req_funct3,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [DM_ADDRESS-1:0]      mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [2:0]                 mem_funct3,
    input  logic [DATA_W-1:0]          mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]     stat_grants,
    output logic [STAT_W-1:0]          stat_conflicts
`endif
);

    localparam int IDXW = $clog2(NREQ);

    state_e                state_q, state_d;
    logic [IDXW-1:0]       owner_q, owner_d;
    logic [IDXW-1:0]       last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [NREQ-1:0]       grant;
    logic [IDXW-1:0]       grant_idx;
    logic                  grant_any;

    // Unpacked views of the packed request payloads.
    logic [DM_ADDRESS-1:0] addr_arr   [NREQ];
    logic [DATA_W-1:0]     wdata_arr  [NREQ];
    logic [2:0]            funct3_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]   = req_addr[gi*DM_ADDRESS +: DM_ADDRESS];
            assign wdata_arr[gi]  = req_wdata[gi*DATA_W +: DATA_W];
            assign funct3_arr[gi] = req_funct3[gi*3 +: 3];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        rdata_d      = rdata_q;
        req_ready    = '0;
        rsp_valid    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready    = grant;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    we_d         = req_we[grant_idx];
                    addr_d       = addr_arr[grant_idx];
                    wdata_d      = wdata_arr[grant_idx];
                    funct3_d     = funct3_arr[grant_idx];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_read  = ~we_q;
                mem_write = we_q;
                // Stores leave the previous load data visible.
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A handshake seen while reset is low would be lost by the reset
        // edge, so neither acceptance nor completion is signalled then.
        if (!rst_n) begin
            req_ready = '0;
            rsp_valid = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDXW'(NREQ - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            rdata_q      <= rdata_d;
        end
    end

    // Address/data/size hold the last accepted access outside ISSUE.
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_funct3 = funct3_q;
    assign rsp_rdata  = rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] grants_q;
    logic [STAT_W-1:0]      conflicts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grants_q    <= '0;
            conflicts_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && (grants_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                    grants_q[i*STAT_W +: STAT_W] <= grants_q[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if ((state_q == ST_IDLE) && ($countones(req_valid) > 1)
                && (conflicts_q != {STAT_W{1'b1}})) begin
                conflicts_q <= conflicts_q + 1'b1;
            end
        end
    end

    assign stat_grants    = grants_q;
    assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (MemRead/MemWrite/a/wd/Funct3/rd) between NREQ requesters, e.g. the core load/store path and a debug/DMA loader.
- Round-robin arbitration with a valid/ready request handshake and a one-cycle response pulse per access.
- Sits between the requesters and the data memory; the memory itself is unchanged.
- Serialises accesses through a 3-state FSM so only one access reaches memory at a time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DM_ADDRESS, 9, memory address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  1 = store, 0 = load.
- req_addr  in  NREQ*DM_ADDRESS  per-requester address, packed; slice i = requester i.
- req_wdata  in  NREQ*DATA_W  store data, packed.
- req_funct3  in  NREQ*3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- req_ready  out  NREQ  one-hot acceptance pulse.
- rsp_valid  out  NREQ  one-hot completion pulse, for loads and stores.
- rsp_rdata  out  DATA_W  load data, valid with rsp_valid.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  DM_ADDRESS  to memory a.
- mem_wdata  out  DATA_W  to memory wd.
- mem_funct3  out  3  to memory Funct3.
- mem_rdata  in  DATA_W  from memory rd.

Behaviour:
- FSM states are IDLE, ISSUE and DONE.
- Reset behaviour:
  - State goes to IDLE.
  - owner=0, last_grant=NREQ-1, so requester 0 wins first.
  - All outputs are 0: req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_funct3.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning from last_grant+1 modulo NREQ.
  - req_ready[winner]=1 combinationally in this cycle; the request is accepted on that edge.
  - On acceptance, latch we/addr/wdata/funct3 and owner=winner, update last_grant=winner, go to ISSUE.
  - If no request is pending: no req_ready, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive mem_read=~we_q and mem_write=we_q, plus mem_addr, mem_wdata and mem_funct3 from the latched values.
  - On the clock edge, capture mem_rdata into rsp_rdata if it is a load; hold the previous value for a store.
  - Go to DONE.
- DONE (exactly 1 cycle):
  - rsp_valid[owner]=1; memory strobes are 0.
  - No acceptance in DONE. Go to IDLE.
- Timing: latency from acceptance to rsp_valid is 2 cycles. Peak throughput is 1 access per 3 cycles.
- Outside ISSUE, mem_read and mem_write are both 0; mem_addr, mem_wdata and mem_funct3 hold their last values.
- Requester rules:
  - A requester keeps req_valid and its payload stable until it sees req_ready.
  - It may drop req_valid before the grant without side effect.
  - It may re-request in the cycle after rsp_valid.
- Simultaneous requests: strict rotation. With all NREQ requesting continuously, each is served once every NREQ accesses, so there is no starvation.
- req_valid rising while the FSM is busy: not accepted until the next IDLE, then arbitrated normally.
- Reset asserted mid-operation (ISSUE or DONE): the access is abandoned, no rsp_valid is issued, and the FSM is in IDLE next cycle. A store already in ISSUE may have completed in memory.
- Funct3 is passed through unmodified. Sign extension and byte lanes are the memory's job.
- mem_read and mem_write are never both 1.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With the macro defined:
  - Adds per-requester 16-bit grant counters, output stat_grants (NREQ*16), which saturate at 16'hFFFF.
  - Adds a 16-bit stat_conflicts counter: counts IDLE cycles where more than one req_valid was set. It also saturates.
  - Both counters are cleared by rst_n.
- Without the macro: those ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/DONE);
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the stats counter width constant (16).
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational; the pointer register stays in dmem_arbiter.

Test Plan:
- Single load, requester 0, addr 9'h010, funct3 LW, memory returns 32'hDEADBEEF:
  - req_ready[0] in cycle T;
  - mem_read=1 only in T+1;
  - rsp_valid[0] with rsp_rdata=32'hDEADBEEF in T+2.
- Single store, requester 1, addr 9'h004, wdata 32'h12345678, funct3 SB:
  - mem_write=1 for exactly 1 cycle with mem_funct3=000;
  - rsp_valid[1] 2 cycles after acceptance.
- Both requesters held valid for 12 accesses:
  - grant order is 0,1,0,1,…;
  - each rsp_valid goes to the correct requester;
  - no cycle has both mem strobes set.
- Requester 0 held valid continuously while requester 1 asserts once: requester 1 is served at the next arbitration, not starved.
- rst_n low during ISSUE of a load:
  - no rsp_valid;
  - all outputs 0 next cycle;
  - requester 0 wins the first access after reset.
- With DMEM_ARB_STATS_EN, 5 contended accesses: stat_grants shows 3 and 2, and stat_conflicts ≥ 1 counted only in IDLE.
